// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store unit between the pipeline MEM stage and a
//            byte-addressed data memory. Accepts one request per handshake,
//            issues size masks, splits misaligned H/W accesses into byte
//            accesses, extends load data and returns a one-cycle response.
//            Build option MISALIGN_TRAP_EN: misaligned H/W accesses are not
//            split but answered immediately with an error.
// Revision : 1.0 - initial release
//==============================================================================
module lsu_mem_ctrl #(
   parameter int ADDR_W = 11,
   parameter int XLEN   = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   // request side (pipeline MEM stage)
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_funct3,
   input  logic [XLEN-1:0]   i_req_addr,
   input  logic [XLEN-1:0]   i_req_wdata,
   // response side
   output logic              o_rsp_valid,
   output logic [XLEN-1:0]   o_rsp_rdata,
   output logic              o_rsp_err,
   // data memory request port
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [XLEN-1:0]   o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   output logic              o_mem_wren,
   input  logic [XLEN-1:0]   i_mem_rdata
);

   // FSM encoding
   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ACC   = 2'd1;
`ifndef MISALIGN_TRAP_EN
   localparam logic [1:0] c_SPLIT = 2'd2;
`endif
   localparam logic [1:0] c_RESP  = 2'd3;

   // funct3 size/sign codes
   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   logic [1:0]        r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [XLEN-1:0]   r_rsp_rdata;

   logic              w_addr_oor;
   logic              w_f3_legal;
   logic              w_req_misalign;
   logic              w_req_err;
   logic [ADDR_W-1:0] w_cur_addr;
   logic [XLEN-1:0]   w_lane;
   logic [3:0]        w_size_mask;

`ifndef MISALIGN_TRAP_EN
   logic [1:0]        r_cnt;
   logic [XLEN-1:0]   r_asm;
   logic [XLEN-1:0]   w_asm_next;
   logic [XLEN-1:0]   w_wshift;
   logic              w_last;
`endif

   // Extend a right-justified load value according to the size/sign code.
   function automatic logic [XLEN-1:0] f_extend(input logic [2:0]      f3,
                                                input logic [XLEN-1:0] v);
      logic [XLEN-1:0] res;
      case (f3)
         c_F3_B:  res = {{(XLEN-8){v[7]}}, v[7:0]};
         c_F3_H:  res = {{(XLEN-16){v[15]}}, v[15:0]};
         c_F3_BU: res = {{(XLEN-8){1'b0}}, v[7:0]};
         c_F3_HU: res = {{(XLEN-16){1'b0}}, v[15:0]};
         default: res = v;
      endcase
      return res;
   endfunction

   // Request decode: address range check and funct3 legality per direction.
   always_comb begin
      w_addr_oor = |i_req_addr[XLEN-1:ADDR_W];
      w_f3_legal = 1'b0;
      case (i_req_funct3)
         c_F3_B, c_F3_H, c_F3_W: w_f3_legal = 1'b1;
         c_F3_BU, c_F3_HU:       w_f3_legal = ~i_req_we;
         default:                w_f3_legal = 1'b0;
      endcase
      // Halfword needs addr[0]=0, word needs addr[1:0]=00; bytes never misalign.
      w_req_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
      w_req_err = w_addr_oor || !w_f3_legal || w_req_misalign;
`else
      w_req_err = w_addr_oor || !w_f3_legal;
`endif
   end

   // Current memory byte address and the read word shifted down to that lane.
   always_comb begin
`ifdef MISALIGN_TRAP_EN
      w_cur_addr = r_addr;
`else
      w_cur_addr = (r_state == c_SPLIT) ? (r_addr + {{(ADDR_W-2){1'b0}}, r_cnt}) : r_addr;
`endif
      w_lane = i_mem_rdata >> {w_cur_addr[1:0], 3'b000};
      case (r_funct3[1:0])
         2'b00:   w_size_mask = 4'b0001;
         2'b01:   w_size_mask = 4'b0011;
         default: w_size_mask = 4'b1111;
      endcase
   end

`ifndef MISALIGN_TRAP_EN
   // Split-path helpers: assembled load value including this cycle's byte,
   // store byte for the current step and last-step detection.
   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[{r_cnt, 3'b000} +: 8] = w_lane[7:0];
      w_wshift   = r_wdata >> {r_cnt, 3'b000};
      w_last     = (r_funct3[1:0] == 2'b01) ? (r_cnt == 2'd1) : (r_cnt == 2'd3);
   end

   // Byte counter and load assembly register for split accesses.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= 2'd0;
         r_asm <= '0;
      end else if (r_state == c_IDLE) begin
         if (i_req_valid) begin
            r_cnt <= 2'd0;
            r_asm <= '0;
         end
      end else if (r_state == c_SPLIT) begin
         r_cnt <= r_cnt + 2'd1;
         r_asm <= w_asm_next;
      end
   end
`endif

   // Main control FSM with registered response outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= c_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         // Response signals are single-cycle pulses.
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         case (r_state)
            c_IDLE: begin
               if (i_req_valid) begin
                  r_we     <= i_req_we;
                  r_funct3 <= i_req_funct3;
                  r_addr   <= i_req_addr[ADDR_W-1:0];
                  r_wdata  <= i_req_wdata;
                  if (w_req_err) begin
                     r_state     <= c_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
`ifndef MISALIGN_TRAP_EN
                  end else if (w_req_misalign) begin
                     r_state <= c_SPLIT;
`endif
                  end else begin
                     r_state <= c_ACC;
                  end
               end
            end
            c_ACC: begin
               r_state     <= c_RESP;
               r_rsp_valid <= 1'b1;
               if (!r_we) begin
                  r_rsp_rdata <= f_extend(r_funct3, w_lane);
               end
            end
`ifndef MISALIGN_TRAP_EN
            c_SPLIT: begin
               if (w_last) begin
                  r_state     <= c_RESP;
                  r_rsp_valid <= 1'b1;
                  if (!r_we) begin
                     r_rsp_rdata <= f_extend(r_funct3, w_asm_next);
                  end
               end
            end
`endif
            c_RESP: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Memory port is only active in the access states; zero elsewhere.
   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = 4'b0000;
      o_mem_wren  = 1'b0;
      case (r_state)
         c_ACC: begin
            o_mem_addr  = w_cur_addr;
            o_mem_bmask = w_size_mask;
            o_mem_wren  = r_we;
            if (r_we) begin
               o_mem_wdata = r_wdata;
            end
         end
`ifndef MISALIGN_TRAP_EN
         c_SPLIT: begin
            o_mem_addr  = w_cur_addr;
            o_mem_bmask = 4'b0001;
            o_mem_wren  = r_we;
            if (r_we) begin
               o_mem_wdata = {{(XLEN-8){1'b0}}, w_wshift[7:0]};
            end
         end
`endif
         default: ;
      endcase
   end

   assign o_req_ready = (r_state == c_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting between the pipeline MEM stage and the byte-addressed data memory; it drives the data memory's request port (initiator side).
- Accepts one load/store request per handshake and issues size-style byte masks.
- Splits misaligned halfword/word accesses into sequential byte accesses, then extracts and sign/zero-extends load data.
- Returns a single-cycle response pulse per accepted request.

Parameters:
- ADDR_W, 11, data memory byte-address width; request addresses with any bit at or above ADDR_W set are out of range.
- XLEN, 32, data width of the request and memory ports.

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit idle and able to accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- i_req_addr  in  XLEN  byte address
- i_req_wdata  in  XLEN  store data, right-justified
- o_rsp_valid  out  1  one-cycle completion pulse, for loads and stores
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- o_rsp_err  out  1  qualifies o_rsp_valid: out-of-range address or illegal funct3
- o_mem_addr  out  ADDR_W  byte address to data memory
- o_mem_wdata  out  XLEN  right-justified write data; memory applies lane shift by addr[1:0]
- o_mem_bmask  out  4  size mask: 0001 byte, 0011 half, 1111 word
- o_mem_wren  out  1  write enable; memory writes on the rising edge
- i_mem_rdata  in  XLEN  combinational read of the full word at o_mem_addr word index; reads 0 while o_mem_wren=1

Behaviour:
- Reset (async) values:
  - state IDLE, o_req_ready=1
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0
  - o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0
- Reset mid-operation:
  - Aborts immediately, with no response.
  - A partially completed split store leaves the bytes already written; this is accepted.
- State IDLE:
  - o_req_ready=1; accept on i_req_valid && o_req_ready.
  - On accept, latch we, funct3, addr, wdata; clear the byte counter and the load assembly register.
  - Transition: error → RESP with err=1; aligned → ACC; misaligned → SPLIT.
- Error conditions:
  - addr[XLEN-1:ADDR_W] != 0.
  - funct3 not in the legal set for the direction: stores accept 000/001/010; loads accept 000/001/010/100/101.
- Alignment rules:
  - H is aligned iff addr[0]=0.
  - W is aligned iff addr[1:0]=00.
  - B is always aligned.
- State ACC (1 cycle):
  - Drive o_mem_addr=addr[ADDR_W-1:0] and the size mask.
  - Store: o_mem_wren=1, o_mem_wdata=wdata.
  - Load: o_mem_wren=0; capture i_mem_rdata at end of cycle.
  - Transition → RESP.
- State SPLIT (N cycles; N=2 for H, 4 for W):
  - Cycle k (k=0..N-1): o_mem_addr=addr+k (wraps modulo 2^ADDR_W), o_mem_bmask=0001.
  - Store: o_mem_wren=1, o_mem_wdata[7:0]=wdata byte k, upper bits 0.
  - Load: capture the byte lane selected by (addr+k)[1:0] from i_mem_rdata into assembly byte k.
  - After k=N-1 → RESP.
- Load extraction (aligned case): select lane by addr[1:0] (H uses addr[1]).
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
  - The split path applies the same extension to the assembled value.
- State RESP (1 cycle):
  - o_rsp_valid=1, o_rsp_rdata/o_rsp_err valid, o_req_ready=0, o_mem_wren=0.
  - Transition → IDLE.
  - o_rsp_valid, o_rsp_rdata and o_rsp_err are registered and return to 0 the following cycle.
- Latency (accept edge = T):
  - aligned: response in cycle T+2
  - split H: response in cycle T+3
  - split W: response in cycle T+5
  - error: response in cycle T+1
- o_req_ready=0 in every state except IDLE, so there is never more than one request outstanding; there is no response backpressure.
- Memory outputs are 0 in IDLE and RESP (o_mem_wren is never asserted outside ACC/SPLIT).

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - The SPLIT state is not compiled.
  - A misaligned H/W request goes straight to RESP with o_rsp_err=1 and no memory access; latency is T+1.
- Undefined: misaligned accesses are split as described above.

Test Plan:
- SW 0xDEADBEEF @0x00C, then LW @0x00C → rsp_rdata=0xDEADBEEF, err=0; mem_wren high exactly 1 cycle with bmask=1111.
- SB 0x12345678 @0x00D, then LW @0x00C → 0xDEAD78EF. Then LB @0x00D → 0x00000078. Then LB @0x00F → 0xFFFFFFDE. Then LBU @0x00F → 0x000000DE.
- SH 0x0000ABCD @0x010, then LH → 0xFFFFABCD, LHU → 0x0000ABCD.
- SW 0xCAFEF00D @0x013 (misaligned) → 4 byte writes to 0x013..0x016, rsp at T+5. LW @0x013 → 0xCAFEF00D. With MISALIGN_TRAP_EN, the same store gives err=1, mem_wren never asserted.
- LW @0x00000800 (out of range) → rsp_valid at T+1, err=1, rdata=0, no memory access. Store with funct3=100 → err=1.
- Assert i_reset during the 2nd byte of a split SW → all outputs 0 next sample, no rsp_valid, o_req_ready=1 after release; a new LW is accepted normally.
